// File: rtl/val2_pkg.sv
// Shared types and constants for the Val2 operand generator.
package val2_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    MODE_MEM = 2'd0,
    MODE_IMM = 2'd1,
    MODE_REG = 2'd2
  } mode_e;

  // Decoded control carried from decode into the shift stage.
  typedef struct packed {
    logic [1:0] sh_type;
    logic       rrx;
    logic       c_in;
  } shift_ctrl_t;

endpackage

// File: rtl/val2_shift_core.sv
// Combinational barrel shifter: resolved value/type/amount in, result and carry-out out.
module val2_shift_core
  import val2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned AMT_W      = 8
) (
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic [1:0]            sh_type_i,
  input  logic [AMT_W-1:0]      amount_i,
  input  logic                  c_in_i,
  input  logic                  rrx_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  carry_o
);

  localparam int unsigned LOG_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH:0]   lsl_w;
  logic [DATA_WIDTH:0]   lsr_w;
  logic [DATA_WIDTH:0]   asr_w;
  logic [DATA_WIDTH-1:0] ror_res;
  logic [LOG_W-1:0]      ror_amt;

  // One extra bit beside the value catches the last bit shifted out, including amount == width.
  always_comb begin
    lsl_w   = {1'b0, value_i} << amount_i;
    lsr_w   = {value_i, 1'b0} >> amount_i;
    asr_w   = $unsigned($signed({value_i, 1'b0}) >>> amount_i);
    ror_amt = amount_i[LOG_W-1:0];
    ror_res = (value_i >> ror_amt)
            | (value_i << ((LOG_W+1)'(DATA_WIDTH) - {1'b0, ror_amt}));

    result_o = value_i;
    carry_o  = c_in_i;
    if (rrx_i) begin
      result_o = {c_in_i, value_i[DATA_WIDTH-1:1]};
      carry_o  = value_i[0];
    end else if (amount_i != '0) begin
      unique case (sh_type_i)
        SH_LSL:  {carry_o, result_o} = lsl_w;
        SH_LSR:  {result_o, carry_o} = lsr_w;
        SH_ASR:  {result_o, carry_o} = asr_w;
        default: begin
          result_o = ror_res;
          carry_o  = ror_res[DATA_WIDTH-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/val2_shifter_pipe.sv
// Pipelined Val2 / shifter-carry generator with valid/ready handshake and flush.
module val2_shifter_pipe
  import val2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] val_rm,
  input  logic [7:0]            val_rs,
  input  logic [11:0]           shift_operand,
  input  logic                  imm,
  input  logic                  mem_access,
  input  logic                  c_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] val2,
  output logic                  shifter_carry
);

  localparam int unsigned LOG_W = $clog2(DATA_WIDTH);
  localparam int unsigned AMT_W = (LOG_W + 1 > 8) ? LOG_W + 1 : 8;

  mode_e                 mode;
  logic [DATA_WIDTH-1:0] s0_value_d;
  logic [AMT_W-1:0]      s0_amt_d;
  shift_ctrl_t           s0_ctrl_d;

  logic [DATA_WIDTH-1:0] core_value;
  logic [AMT_W-1:0]      core_amt;
  shift_ctrl_t           core_ctrl;
  logic                  core_valid;
  logic [DATA_WIDTH-1:0] core_res;
  logic                  core_carry;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] val2_q;
  logic                  carry_q;
  logic                  out_adv;

  // Resolve mode priority and the special immediate-amount-zero encodings into a plain shift.
  always_comb begin
    mode = MODE_REG;
    if (mem_access) begin
      mode = MODE_MEM;
    end else if (imm) begin
      mode = MODE_IMM;
    end

    s0_value_d        = val_rm;
    s0_amt_d          = '0;
    s0_ctrl_d.sh_type = shift_operand[6:5];
    s0_ctrl_d.rrx     = 1'b0;
    s0_ctrl_d.c_in    = c_in;

    unique case (mode)
      MODE_MEM: begin
        s0_value_d        = DATA_WIDTH'(shift_operand);
        s0_ctrl_d.sh_type = SH_LSL;
      end
      MODE_IMM: begin
        s0_value_d        = DATA_WIDTH'(shift_operand[7:0]);
        s0_ctrl_d.sh_type = SH_ROR;
        s0_amt_d          = AMT_W'({shift_operand[11:8], 1'b0}) & AMT_W'(DATA_WIDTH - 1);
      end
      MODE_REG: begin
        if (shift_operand[4]) begin
          s0_amt_d = AMT_W'(val_rs);
        end else if (shift_operand[11:7] != 5'd0) begin
          s0_amt_d = AMT_W'(shift_operand[11:7]);
        end else if (shift_operand[6:5] == SH_ROR) begin
          s0_ctrl_d.rrx = 1'b1;
        end else if (shift_operand[6:5] != SH_LSL) begin
          s0_amt_d = AMT_W'(DATA_WIDTH);
        end
      end
      default: ;
    endcase
  end

  assign out_adv = !out_valid_q || out_ready;

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic                  s0_valid_q;
      logic [DATA_WIDTH-1:0] s0_value_q;
      logic [AMT_W-1:0]      s0_amt_q;
      shift_ctrl_t           s0_ctrl_q;

      assign in_ready = !s0_valid_q || out_adv;

      always_ff @(posedge clk) begin
        if (rst) begin
          s0_valid_q <= 1'b0;
          s0_value_q <= '0;
          s0_amt_q   <= '0;
          s0_ctrl_q  <= '0;
        end else if (flush) begin
          s0_valid_q <= 1'b0;
        end else if (in_ready) begin
          s0_valid_q <= in_valid;
          if (in_valid) begin
            s0_value_q <= s0_value_d;
            s0_amt_q   <= s0_amt_d;
            s0_ctrl_q  <= s0_ctrl_d;
          end
        end
      end

      assign core_valid = s0_valid_q;
      assign core_value = s0_value_q;
      assign core_amt   = s0_amt_q;
      assign core_ctrl  = s0_ctrl_q;
    end else begin : g_one
      assign in_ready   = out_adv;
      assign core_valid = in_valid;
      assign core_value = s0_value_d;
      assign core_amt   = s0_amt_d;
      assign core_ctrl  = s0_ctrl_d;
    end
  endgenerate

  val2_shift_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .AMT_W      (AMT_W)
  ) u_core (
    .value_i   (core_value),
    .sh_type_i (core_ctrl.sh_type),
    .amount_i  (core_amt),
    .c_in_i    (core_ctrl.c_in),
    .rrx_i     (core_ctrl.rrx),
    .result_o  (core_res),
    .carry_o   (core_carry)
  );

  // Output stage holds its data while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      val2_q      <= '0;
      carry_q     <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_adv) begin
      out_valid_q <= core_valid;
      if (core_valid) begin
        val2_q  <= core_res;
        carry_q <= core_carry;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign val2          = val2_q;
  assign shifter_carry = carry_q;

endmodule

// File: tb/tb_val2_shifter_pipe.sv
// Bench for val2_shifter_pipe: one- and two-stage instances driven from a vector table and a scoreboard.
module tb_val2_shifter_pipe;

  typedef struct {
    logic [31:0] rm;
    logic [7:0]  rs;
    logic [11:0] so;
    logic        imm;
    logic        mem;
    logic        c;
    logic [31:0] exp_val2;
    logic        exp_carry;
  } vec_t;

  typedef struct packed {
    logic        carry;
    logic [31:0] val2;
  } exp_t;

  localparam int NT = 21;

  logic        clk, rst, flush, in_valid, out_ready, imm, mem_access, c_in, sel;
  logic [31:0] val_rm;
  logic [7:0]  val_rs;
  logic [11:0] shift_operand;
  logic        in_ready1, in_ready2, out_valid1, out_valid2, carry1, carry2;
  logic [31:0] val2_1, val2_2;
  logic        in_ready_m, out_valid_m, carry_m;
  logic [31:0] val2_m;

  int    tests, fails;
  exp_t  sb[$];
  logic  hold_valid;
  exp_t  hold;
  string cur_tag;
  vec_t  tab[NT];
  vec_t  zv;

  val2_shifter_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid & ~sel), .in_ready(in_ready1),
    .val_rm(val_rm), .val_rs(val_rs), .shift_operand(shift_operand), .imm(imm),
    .mem_access(mem_access), .c_in(c_in), .out_valid(out_valid1), .out_ready(out_ready),
    .val2(val2_1), .shifter_carry(carry1)
  );

  val2_shifter_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid & sel), .in_ready(in_ready2),
    .val_rm(val_rm), .val_rs(val_rs), .shift_operand(shift_operand), .imm(imm),
    .mem_access(mem_access), .c_in(c_in), .out_valid(out_valid2), .out_ready(out_ready),
    .val2(val2_2), .shifter_carry(carry2)
  );

  assign in_ready_m  = sel ? in_ready2  : in_ready1;
  assign out_valid_m = sel ? out_valid2 : out_valid1;
  assign val2_m      = sel ? val2_2     : val2_1;
  assign carry_m     = sel ? carry2     : carry1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%s]: got %0h, expected %0h", name, cur_tag, act, exp);
    end
  endtask

  // Reference behaviour written directly from the ARM operand-2 rules.
  function automatic exp_t model(input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] so,
                                 input logic im, input logic mem, input logic c);
    exp_t e;
    int amt, r;
    logic [31:0] v;
    e.val2  = rm;
    e.carry = c;
    if (mem) begin
      e.val2 = {20'd0, so};
    end else if (im) begin
      r = 2 * int'(so[11:8]);
      v = {24'd0, so[7:0]};
      if (r == 0) begin
        e.val2 = v;
      end else begin
        e.val2  = (v >> r) | (v << (32 - r));
        e.carry = e.val2[31];
      end
    end else begin
      amt = so[4] ? int'(rs) : int'(so[11:7]);
      if (!so[4] && amt == 0) begin
        case (so[6:5])
          2'b00: ;
          2'b01: begin e.val2 = 32'd0; e.carry = rm[31]; end
          2'b10: begin e.val2 = {32{rm[31]}}; e.carry = rm[31]; end
          default: begin e.val2 = {c, rm[31:1]}; e.carry = rm[0]; end
        endcase
      end else if (amt != 0) begin
        case (so[6:5])
          2'b00: begin
            if (amt < 32) begin e.val2 = rm << amt; e.carry = rm[32-amt]; end
            else if (amt == 32) begin e.val2 = 32'd0; e.carry = rm[0]; end
            else begin e.val2 = 32'd0; e.carry = 1'b0; end
          end
          2'b01: begin
            if (amt < 32) begin e.val2 = rm >> amt; e.carry = rm[amt-1]; end
            else if (amt == 32) begin e.val2 = 32'd0; e.carry = rm[31]; end
            else begin e.val2 = 32'd0; e.carry = 1'b0; end
          end
          2'b10: begin
            if (amt < 32) begin e.val2 = $unsigned($signed(rm) >>> amt); e.carry = rm[amt-1]; end
            else begin e.val2 = {32{rm[31]}}; e.carry = rm[31]; end
          end
          default: begin
            r = amt % 32;
            if (r == 0) begin e.val2 = rm; e.carry = rm[31]; end
            else begin e.val2 = (rm >> r) | (rm << (32 - r)); e.carry = rm[r-1]; end
          end
        endcase
      end
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] so,
                              input logic im, input logic mem, input logic c,
                              input logic [31:0] ev, input logic ec);
    vec_t x;
    x.rm = rm; x.rs = rs; x.so = so; x.imm = im; x.mem = mem; x.c = c;
    x.exp_val2 = ev; x.exp_carry = ec;
    return x;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t x;
    exp_t e;
    int k;
    x.rm = $urandom();
    k = $urandom_range(0, 5);
    case (k)
      0: x.rs = 8'd0;
      1: x.rs = 8'd31;
      2: x.rs = 8'd32;
      3: x.rs = 8'd33;
      default: x.rs = 8'($urandom());
    endcase
    x.so  = 12'($urandom());
    x.mem = ($urandom_range(0, 7) == 0);
    x.imm = ($urandom_range(0, 3) == 0);
    x.c   = 1'($urandom());
    e = model(x.rm, x.rs, x.so, x.imm, x.mem, x.c);
    x.exp_val2  = e.val2;
    x.exp_carry = e.carry;
    return x;
  endfunction

  // One clock: drive at negedge, sample handshakes 1ns later, update scoreboard.
  task automatic cycle(input logic v, input vec_t x, input logic ordy, input logic fl,
                       output logic acc, output logic ov);
    exp_t e;
    @(negedge clk);
    in_valid = v; val_rm = x.rm; val_rs = x.rs; shift_operand = x.so;
    imm = x.imm; mem_access = x.mem; c_in = x.c; out_ready = ordy; flush = fl;
    #1;
    ov = out_valid_m;
    if (hold_valid)
      check("stall_hold", {30'd0, out_valid_m, carry_m, val2_m}, {30'd0, 1'b1, hold.carry, hold.val2});
    if (out_valid_m && ordy) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_out [%s]: got val2 %0h with no item expected", cur_tag, val2_m);
      end else begin
        e = sb.pop_front();
        check("val2", 64'(val2_m), 64'(e.val2));
        check("carry", 64'(carry_m), 64'(e.carry));
      end
    end
    hold_valid = out_valid_m && !ordy && !fl;
    hold       = {carry_m, val2_m};
    acc        = v && in_ready_m && !fl;
    if (fl) sb.delete();
    if (acc) sb.push_back({x.exp_carry, x.exp_val2});
  endtask

  task automatic send(input vec_t x, input logic ordy);
    logic a, o;
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++) cycle(1'b1, x, ordy, 1'b0, a, o);
    if (!a) begin
      tests++;
      fails++;
      $display("FAIL send_timeout [%s]: got in_ready low for 20 cycles, expected acceptance", cur_tag);
    end
  endtask

  task automatic drain();
    logic a, o;
    for (int k = 0; k < 30 && sb.size() > 0; k++) cycle(1'b0, zv, 1'b1, 1'b0, a, o);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_out_valid1", 64'(out_valid1), 64'd0);
    check("rst_val2_1",     64'(val2_1),     64'd0);
    check("rst_carry1",     64'(carry1),     64'd0);
    check("rst_in_ready1",  64'(in_ready1),  64'd1);
    check("rst_out_valid2", 64'(out_valid2), 64'd0);
    check("rst_val2_2",     64'(val2_2),     64'd0);
    check("rst_carry2",     64'(carry2),     64'd0);
    check("rst_in_ready2",  64'(in_ready2),  64'd1);
    rst = 1'b0;
    sb.delete();
    hold_valid = 1'b0;
  endtask

  initial begin
    logic a, o;
    int   lat, idx;
    vec_t bp[8];

    tests = 0; fails = 0; sel = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; imm = 1'b0; mem_access = 1'b0; c_in = 1'b0; val_rm = '0;
    val_rs = '0; shift_operand = '0; hold_valid = 1'b0; hold = '0; cur_tag = "reset";
    zv = mk(32'd0, 8'd0, 12'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    tab[0]  = mk(32'h0,        8'd0,  12'hABC, 1'b0, 1'b1, 1'b1, 32'h00000ABC, 1'b1);
    tab[1]  = mk(32'h0,        8'd0,  12'h2FF, 1'b1, 1'b0, 1'b0, 32'hF000000F, 1'b1);
    tab[2]  = mk(32'h0,        8'd0,  12'h0FF, 1'b1, 1'b0, 1'b0, 32'h000000FF, 1'b0);
    tab[3]  = mk(32'h0,        8'd0,  12'h0FF, 1'b1, 1'b0, 1'b1, 32'h000000FF, 1'b1);
    tab[4]  = mk(32'h80000001, 8'd0,  12'h020, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1);
    tab[5]  = mk(32'h80000001, 8'd40, 12'h050, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1);
    tab[6]  = mk(32'h80000001, 8'd0,  12'h060, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b1);
    tab[7]  = mk(32'h80000001, 8'd32, 12'h010, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1);
    tab[8]  = mk(32'h80000001, 8'd33, 12'h010, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0);
    tab[9]  = mk(32'h12345678, 8'd0,  12'h000, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1);
    tab[10] = mk(32'h80000001, 8'd0,  12'h030, 1'b0, 1'b0, 1'b0, 32'h80000001, 1'b0);
    tab[11] = mk(32'h80000001, 8'd32, 12'h030, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1);
    tab[12] = mk(32'h80000001, 8'd33, 12'h030, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0);
    tab[13] = mk(32'h80000001, 8'd32, 12'h070, 1'b0, 1'b0, 1'b0, 32'h80000001, 1'b1);
    tab[14] = mk(32'h80000001, 8'd36, 12'h070, 1'b0, 1'b0, 1'b0, 32'h18000000, 1'b0);
    tab[15] = mk(32'hF000000F, 8'd0,  12'h200, 1'b0, 1'b0, 1'b0, 32'h000000F0, 1'b1);
    tab[16] = mk(32'h80000010, 8'd0,  12'h240, 1'b0, 1'b0, 1'b0, 32'hF8000001, 1'b0);
    tab[17] = mk(32'h7FFFFFFF, 8'd0,  12'h040, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0);
    tab[18] = mk(32'h0,        8'd0,  12'h2FF, 1'b1, 1'b1, 1'b0, 32'h000002FF, 1'b0);
    tab[19] = mk(32'h00000002, 8'd0,  12'h060, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b0);
    tab[20] = mk(32'h80000001, 8'd0,  12'h070, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b1);

    repeat (2) @(negedge clk);
    do_reset();

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);

      for (int i = 0; i < NT; i++) begin
        cur_tag = $sformatf("s%0d vec%0d", s + 1, i);
        send(tab[i], 1'b1);
      end
      drain();

      cur_tag = $sformatf("s%0d latency", s + 1);
      send(tab[0], 1'b1);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        cycle(1'b0, zv, 1'b1, 1'b0, a, o);
        if (o) begin
          lat = k;
          break;
        end
      end
      check("latency", 64'(lat), sel ? 64'd2 : 64'd1);
      drain();

      cur_tag = $sformatf("s%0d backpressure", s + 1);
      for (int i = 0; i < 8; i++) bp[i] = rnd_vec();
      idx = 0;
      for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
        cycle(1'b1, bp[idx], !(cyc >= 3 && cyc <= 6), 1'b0, a, o);
        if (a) idx++;
      end
      check("bp_issued", 64'(idx), 64'd8);
      drain();

      cur_tag = $sformatf("s%0d flush", s + 1);
      send(rnd_vec(), 1'b0);
      if (sel) send(rnd_vec(), 1'b0);
      cycle(1'b1, rnd_vec(), 1'b0, 1'b1, a, o);
      cycle(1'b0, zv, 1'b1, 1'b0, a, o);
      check("flush_out_valid", 64'(o), 64'd0);
      send(tab[5], 1'b1);
      drain();

      cur_tag = $sformatf("s%0d random", s + 1);
      for (int k = 0; k < 60; k++)
        cycle($urandom_range(0, 3) != 0, rnd_vec(), $urandom_range(0, 9) < 7, 1'b0, a, o);
      drain();

      cur_tag = $sformatf("s%0d midreset", s + 1);
      cycle(1'b1, rnd_vec(), 1'b0, 1'b0, a, o);
      cycle(1'b1, rnd_vec(), 1'b0, 1'b0, a, o);
      do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
